ntt_frame_ctrl: RTL and testbench
=================================

# ntt_frame_ctrl

Frame-level sequencer for the pipelined NTT/INTT datapath. It accepts one polynomial transform job at a time: a forward NTT or an inverse NTT on a PAIRS-pair polynomial held in a coefficient RAM. It streams the coefficient pairs from the RAM into the selected pipeline, collects the pipeline's output pairs, and writes them back in arrival order. It signals completion, or a timeout error if the pipeline stalls. The block sits between the coefficient RAM and the ntt/intt pipeline ports.

## Interface
- DATA_WIDTH, 12: coefficient width.
- PAIRS, 128: coefficient pairs per polynomial; power of two.
- TIMEOUT, 1024: maximum cycles allowed without an output pair during DRAIN.
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  job request.
- req_inv  in  1  0 = forward NTT, 1 = inverse NTT; sampled on accept.
- req_ready  out  1  high only in IDLE.
- rd_en  out  1  RAM read strobe; RAM returns data exactly 1 cycle later.
- rd_addr  out  log2(PAIRS)  pair index being read.
- rd_data1, rd_data2  in  DATA_WIDTH each  pair returned from the RAM.
- ntt_in_en, intt_in_en  out  1 each  pipeline input strobes.
- dp_in1, dp_in2  out  DATA_WIDTH each  pair driven to both pipelines.
- ntt_out_en, intt_out_en  in  1 each  pipeline output strobes.
- ntt_out1, ntt_out2, intt_out1, intt_out2  in  DATA_WIDTH each  pipeline output pairs.
- wr_en  out  1  RAM write strobe.
- wr_addr  out  log2(PAIRS)  write index.
- wr_data1, wr_data2  out  DATA_WIDTH each  pair written to the RAM.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on timeout.

## Operation
- States: IDLE, FEED, DRAIN, FINISH.
- IDLE
  - req_ready=1.
  - On req_valid: latch req_inv into mode, clear rd_cnt, out_cnt and wd_cnt, then go to FEED.
- FEED
  - rd_en=1 and rd_addr=rd_cnt every cycle; rd_cnt increments.
  - After the read with rd_cnt=PAIRS-1, go to DRAIN.
- Input stage
  - A registered copy of rd_en drives the selected in_en on the following cycle (ntt_in_en when mode=0, intt_in_en when mode=1).
  - dp_in1/dp_in2 carry rd_data1/rd_data2 on that same cycle.
  - The non-selected in_en stays 0.
  - Exactly PAIRS in_en pulses occur per job.
- Output collection (active in FEED and DRAIN)
  - Each selected out_en drives wr_en=1 combinationally in the same cycle, with wr_addr=out_cnt and wr_data taken from the selected pipeline's outputs; out_cnt then increments.
  - The non-selected out_en is ignored entirely.
  - out_en seen in IDLE or FINISH is ignored.
- Completion
  - When an output is accepted with out_cnt=PAIRS-1, go to FINISH from either FEED or DRAIN.
  - out_cnt saturates; surplus out_en pulses are never written.
- DRAIN
  - wd_cnt increments every cycle and clears on each accepted output.
  - If wd_cnt reaches TIMEOUT-1 with no output accepted in that cycle: err=1 for one cycle, then go to IDLE.
- FINISH: done=1 for one cycle, then go to IDLE.
- Exiting via FINISH or via timeout forces rd_en and in_en low.
- rst in any state: state=IDLE, all counters cleared, any in-flight job abandoned.

## Timing
- Reset values: req_ready=1; all other outputs 0 (busy, done, err, rd_en, rd_addr, in_en both, dp_in both, wr_en, wr_addr, wr_data both).
- Job accepted at edge T (req_valid&&req_ready):
  - rd_en is high in cycles T+1..T+PAIRS, with rd_addr=0..PAIRS-1.
  - in_en is high in cycles T+2..T+PAIRS+1.
- If the pipeline latency is L cycles from in_en to out_en:
  - done is asserted in cycle T+PAIRS+1+L+1, i.e. the cycle after the last out_en.
  - req_ready returns high the cycle after done.
- Minimum gap between jobs is 1 IDLE cycle.
- wr_en/wr_addr/wr_data are combinational from out_en and out_cnt, so the write lands in the same cycle as the output pair.
- req_valid arriving while busy is not accepted; the requester holds it.
- mode never changes mid-job.

## Test plan
- Forward job, PAIRS=128, pipeline model L=20, RAM pair i={i, i+1000}:
  - rd_addr runs 0..127 over 128 cycles; ntt_in_en pulses exactly 128 times and intt_in_en stays 0.
  - wr_addr runs 0..127 and done pulses exactly once.
  - Total cycles from accept to done is 150.
- Inverse job with L=3, so outputs start during FEED:
  - Writes overlap reads, wr_addr is in order, done pulses once.
  - Spurious ntt_out_en pulses are injected during the job and cause no writes.
- Pipeline model stops after 100 outputs, TIMEOUT=16:
  - err pulses 16 cycles after the last output, done stays 0.
  - req_ready returns high on the next cycle.
- Reset mid-FEED at rd_addr=50:
  - The cycle after reset, all outputs are at their reset values.
  - A new job issued afterwards completes normally.
- Back-to-back requests with req_valid held high:
  - The second job is accepted exactly 1 cycle after the first done.
  - Its mode is the req_inv sampled at that accept.
- Surplus outputs: model emits 130 out_en pulses; exactly 128 writes occur and done pulses once.

Source files
------------

// File: rtl/ntt_frame_ctrl.sv
// ntt_frame_ctrl
// Frame sequencer for the NTT/INTT pipelines. It streams PAIRS coefficient
// pairs out of the coefficient RAM into the selected pipeline. Each output pair
// is written back to the RAM in arrival order. A watchdog aborts the job if the
// pipeline stops producing outputs while draining.
module ntt_frame_ctrl #(
  parameter  int DATA_WIDTH = 12,
  parameter  int PAIRS      = 128,
  parameter  int TIMEOUT    = 1024,
  localparam int AW         = $clog2(PAIRS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_inv,
  output logic                  req_ready,
  output logic                  rd_en,
  output logic [AW-1:0]         rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data1,
  input  logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  ntt_in_en,
  output logic                  intt_in_en,
  output logic [DATA_WIDTH-1:0] dp_in1,
  output logic [DATA_WIDTH-1:0] dp_in2,
  input  logic                  ntt_out_en,
  input  logic                  intt_out_en,
  input  logic [DATA_WIDTH-1:0] ntt_out1,
  input  logic [DATA_WIDTH-1:0] ntt_out2,
  input  logic [DATA_WIDTH-1:0] intt_out1,
  input  logic [DATA_WIDTH-1:0] intt_out2,
  output logic                  wr_en,
  output logic [AW-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data1,
  output logic [DATA_WIDTH-1:0] wr_data2,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int              WDW      = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0]   LAST_IDX = AW'(PAIRS - 1);
  localparam logic [WDW-1:0]  WD_LIMIT = WDW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FEED   = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic           mode_q;      // 0 = forward NTT, 1 = inverse NTT
  logic [AW-1:0]  rd_cnt_q;
  logic [AW-1:0]  out_cnt_q;
  logic [WDW-1:0] wd_cnt_q;
  logic           in_en_q;     // RAM data valid this cycle (read issued last cycle)

  logic collecting;
  logic sel_out_en;
  logic out_acc;
  logic last_out;
  logic last_rd;
  logic timeout;

  // Outputs are collected only while a job is streaming or draining. Only the
  // pipeline that matches the job mode is listened to.
  assign collecting = (state_q == S_FEED) || (state_q == S_DRAIN);
  assign sel_out_en = mode_q ? intt_out_en : ntt_out_en;
  assign out_acc    = collecting && sel_out_en;
  assign last_out   = out_acc && (out_cnt_q == LAST_IDX);
  assign last_rd    = (state_q == S_FEED) && (rd_cnt_q == LAST_IDX);
  assign timeout    = (state_q == S_DRAIN) && (wd_cnt_q == WD_LIMIT) && !out_acc;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; completion takes priority over the end of the read phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = S_FEED;
      S_FEED: begin
        if (last_out)     state_d = S_FINISH;
        else if (last_rd) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_out)     state_d = S_FINISH;
        else if (timeout) state_d = S_IDLE;
      end
      default:            state_d = S_IDLE;
    endcase
  end

  // Job mode, read/write counters and drain watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= 1'b0;
      rd_cnt_q  <= '0;
      out_cnt_q <= '0;
      wd_cnt_q  <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        mode_q    <= req_inv;
        rd_cnt_q  <= '0;
        out_cnt_q <= '0;
        wd_cnt_q  <= '0;
      end else begin
        if (state_q == S_FEED) rd_cnt_q <= rd_cnt_q + 1'b1;
        // out_cnt holds at the last index so surplus pulses can never wrap it
        if (out_acc && out_cnt_q != LAST_IDX) out_cnt_q <= out_cnt_q + 1'b1;
        if (out_acc)                  wd_cnt_q <= '0;
        else if (state_q == S_DRAIN)  wd_cnt_q <= wd_cnt_q + 1'b1;
      end
    end
  end

  // Input strobe follows the read strobe by one cycle. It is dropped when the
  // job ends early, either by completion or by timeout.
  always_ff @(posedge clk) begin
    if (rst) in_en_q <= 1'b0;
    else     in_en_q <= (state_q == S_FEED) &&
                        (state_d == S_FEED || state_d == S_DRAIN);
  end

  // Output decode
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_FINISH);
    err        = timeout;
    rd_en      = (state_q == S_FEED);
    rd_addr    = (state_q == S_FEED) ? rd_cnt_q : '0;
    ntt_in_en  = in_en_q && !mode_q;
    intt_in_en = in_en_q && mode_q;
    dp_in1     = in_en_q ? rd_data1 : '0;
    dp_in2     = in_en_q ? rd_data2 : '0;
    wr_en      = out_acc;
    wr_addr    = out_acc ? out_cnt_q : '0;
    wr_data1   = '0;
    wr_data2   = '0;
    if (out_acc) begin
      wr_data1 = mode_q ? intt_out1 : ntt_out1;
      wr_data2 = mode_q ? intt_out2 : ntt_out2;
    end
  end

endmodule

// File: tb/tb_ntt_frame_ctrl.sv
// Testbench for ntt_frame_ctrl: RAM and FIFO-pipeline models around the DUT,
// with per-job expectations derived from the RAM contents.
module tb_ntt_frame_ctrl;
  localparam int DW = 12, PAIRS = 128, TMO = 16, AW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, req_valid, req_inv, req_ready, rd_en, ntt_in_en, intt_in_en;
  logic ntt_out_en, intt_out_en, wr_en, busy, done, err;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data1, rd_data2, dp_in1, dp_in2, wr_data1, wr_data2;
  logic [DW-1:0] ntt_out1, ntt_out2, intt_out1, intt_out2;

  ntt_frame_ctrl #(.DATA_WIDTH(DW), .PAIRS(PAIRS), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_inv(req_inv),
    .req_ready(req_ready), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .ntt_in_en(ntt_in_en),
    .intt_in_en(intt_in_en), .dp_in1(dp_in1), .dp_in2(dp_in2),
    .ntt_out_en(ntt_out_en), .intt_out_en(intt_out_en), .ntt_out1(ntt_out1),
    .ntt_out2(ntt_out2), .intt_out1(intt_out1), .intt_out2(intt_out2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data1(wr_data1), .wr_data2(wr_data2),
    .busy(busy), .done(done), .err(err));

  // All outputs except req_ready, which must be zero at reset
  logic [68:0] outs_now;
  assign outs_now = {busy, done, err, rd_en, rd_addr, ntt_in_en, intt_in_en, dp_in1,
                     dp_in2, wr_en, wr_addr, wr_data1, wr_data2};

  int total = 0, bad = 0;
  int cyc = 0;
  logic [DW-1:0] ram1 [PAIRS];
  logic [DW-1:0] ram2 [PAIRS];

  // Pipeline model configuration
  int cfg_lat = 20, cfg_limit = 1000, cfg_extra = 0;
  bit cfg_spur = 1'b0;

  typedef struct { int due; bit inv; logic [DW-1:0] d1; logic [DW-1:0] d2; } pend_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [DW-1:0] d1; logic [DW-1:0] d2; } wr_t;
  pend_t pipe_q[$];
  pend_t env_p;
  wr_t   wr_log[$];

  int rd_cnt, rd_first, rd_last, rd_bad, in_ntt, in_intt, in_bad, emitted, spur_cnt;
  int done_cnt, done_cyc, err_cnt, err_cyc, acc_cnt, acc_cyc, mon_k;
  bit acc_inv, ready_after_done, ready_after_err;
  logic rd_pend = 1'b0;
  logic [AW-1:0] rd_pend_addr = '0;

  // Pipeline transforms: any fixed per-pair function will do
  function automatic logic [DW-1:0] xf1(bit inv, logic [DW-1:0] d);
    return inv ? d + DW'(12'h111) : d ^ DW'(12'hA5A);
  endfunction
  function automatic logic [DW-1:0] xf2(bit inv, logic [DW-1:0] d);
    return inv ? ~d : d + DW'(7);
  endfunction

  // Reference: the k-th write must be address k carrying xf(RAM[k])
  function automatic int write_errors(bit inv, int n);
    int e = 0;
    if (wr_log.size() != n) e++;
    foreach (wr_log[i])
      if (i >= n || wr_log[i].addr != AW'(i) || wr_log[i].d1 !== xf1(inv, ram1[i]) ||
          wr_log[i].d2 !== xf2(inv, ram2[i])) e++;
    return e;
  endfunction

  task automatic reset_env();
    pipe_q.delete(); wr_log.delete();
    rd_cnt = 0; rd_first = -1; rd_last = -1; rd_bad = 0; in_ntt = 0; in_intt = 0;
    in_bad = 0; emitted = 0; spur_cnt = 0; done_cnt = 0; done_cyc = -10;
    err_cnt = 0; err_cyc = -10; acc_cnt = 0; acc_cyc = -10;
    ready_after_done = 1'b0; ready_after_err = 1'b0;
  endtask

  task automatic fill_ram(bit ramp);
    for (int i = 0; i < PAIRS; i++) begin
      ram1[i] = ramp ? DW'(i) : DW'($urandom);
      ram2[i] = ramp ? DW'(i + 1000) : DW'($urandom);
    end
  endtask

  task automatic smp(); @(negedge clk); #1; endtask
  task automatic drv(); @(posedge clk); #2; endtask

  // RAM read response and pipeline outputs, driven just after each edge
  always @(posedge clk) begin
    cyc++;
    #1;
    rd_data1 = rd_pend ? ram1[rd_pend_addr] : DW'($urandom);
    rd_data2 = rd_pend ? ram2[rd_pend_addr] : DW'($urandom);
    ntt_out_en = 1'b0; intt_out_en = 1'b0;
    ntt_out1 = DW'($urandom); ntt_out2 = DW'($urandom);
    intt_out1 = DW'($urandom); intt_out2 = DW'($urandom);
    if (pipe_q.size() > 0 && pipe_q[0].due <= cyc && emitted < cfg_limit) begin
      env_p = pipe_q.pop_front();
      emitted++;
      if (env_p.inv) begin
        intt_out_en = 1'b1; intt_out1 = xf1(1'b1, env_p.d1); intt_out2 = xf2(1'b1, env_p.d2);
      end else begin
        ntt_out_en = 1'b1; ntt_out1 = xf1(1'b0, env_p.d1); ntt_out2 = xf2(1'b0, env_p.d2);
      end
    end
    if (cfg_spur && $urandom_range(0, 2) == 0) begin
      ntt_out_en = 1'b1;
      spur_cnt++;
    end
  end

  // Mid-cycle monitor: records reads, pipeline inputs, writes and status pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_en) begin
        if (rd_cnt == 0) rd_first = cyc;
        rd_last = cyc;
        if (rd_addr != AW'(rd_cnt)) rd_bad++;
        rd_cnt++;
      end
      if (ntt_in_en || intt_in_en) begin
        mon_k = in_ntt + in_intt;
        if (ntt_in_en) in_ntt++;
        if (intt_in_en) in_intt++;
        if (mon_k >= PAIRS) in_bad++;
        else if (dp_in1 !== ram1[mon_k] || dp_in2 !== ram2[mon_k]) in_bad++;
        pipe_q.push_back('{cyc + cfg_lat, intt_in_en, dp_in1, dp_in2});
        if (mon_k == PAIRS - 1)
          for (int e = 1; e <= cfg_extra; e++)
            pipe_q.push_back('{cyc + cfg_lat + e, intt_in_en, dp_in1, dp_in2});
      end
      if (wr_en) wr_log.push_back('{cyc, wr_addr, wr_data1, wr_data2});
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (cyc == done_cyc + 1) ready_after_done = req_ready;
      if (cyc == err_cyc + 1) ready_after_err = req_ready;
      if (req_valid && req_ready) begin acc_cnt++; acc_cyc = cyc; acc_inv = req_inv; end
    end
    rd_pend = rd_en;
    rd_pend_addr = rd_addr;
  end

  task automatic start_job(bit inv);
    int n = 0;
    drv(); req_valid = 1'b1; req_inv = inv;
    do begin smp(); n++; end while (acc_cnt == 0 && n < 50);
    total++;
    if (acc_cnt == 0) begin bad++; $display("FAIL accept: acc_cnt=%0d required 1", acc_cnt); end
    drv(); req_valid = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    do begin smp(); n++; end while (done_cnt == 0 && err_cnt == 0 && n < 400);
    total++;
    if (n >= 400) begin bad++; $display("FAIL job_end: no done/err within 400 cycles"); end
    repeat (6) smp();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_inv = 1'b0;
    repeat (3) @(posedge clk);
    smp();
    total++; if (outs_now !== '0) begin bad++; $display("FAIL reset_outs: got %h required 0", outs_now); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b required 1", req_ready); end
    drv(); rst = 1'b0;
    smp();
    total++; if (outs_now !== '0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL idle_outs: got %h ready=%b required 0 ready=1", outs_now, req_ready); end
    $display("test_reset done");
  endtask

  task automatic test_forward();
    fill_ram(1'b1); cfg_lat = 20; cfg_limit = 1000; cfg_extra = 0; cfg_spur = 1'b0;
    reset_env(); start_job(1'b0); wait_end();
    total++; if (rd_cnt != PAIRS || rd_bad != 0) begin bad++; $display("FAIL fwd_reads: count=%0d badaddr=%0d required 128/0", rd_cnt, rd_bad); end
    total++; if (rd_first != acc_cyc + 1 || rd_last != acc_cyc + PAIRS) begin
      bad++; $display("FAIL fwd_rd_window: %0d..%0d required %0d..%0d", rd_first - acc_cyc, rd_last - acc_cyc, 1, PAIRS); end
    total++; if (in_ntt != PAIRS || in_intt != 0 || in_bad != 0) begin
      bad++; $display("FAIL fwd_in_en: ntt=%0d intt=%0d baddata=%0d required 128/0/0", in_ntt, in_intt, in_bad); end
    total++; if (write_errors(1'b0, PAIRS) != 0) begin
      bad++; $display("FAIL fwd_writes: %0d bad of %0d required 0 of 128", write_errors(1'b0, PAIRS), wr_log.size()); end
    total++; if (done_cnt != 1 || err_cnt != 0) begin bad++; $display("FAIL fwd_done: done=%0d err=%0d required 1/0", done_cnt, err_cnt); end
    total++; if (done_cyc - acc_cyc != 150) begin bad++; $display("FAIL fwd_latency: got %0d required 150", done_cyc - acc_cyc); end
    total++; if (ready_after_done !== 1'b1) begin bad++; $display("FAIL fwd_ready: got %b required 1", ready_after_done); end
    $display("test_forward done: done at +%0d, %0d writes", done_cyc - acc_cyc, wr_log.size());
  endtask

  task automatic test_inverse_overlap();
    fill_ram(1'b0); cfg_lat = 3; cfg_limit = 1000; cfg_extra = 0; cfg_spur = 1'b1;
    reset_env(); start_job(1'b1); wait_end(); cfg_spur = 1'b0;
    total++; if (in_intt != PAIRS || in_ntt != 0 || in_bad != 0) begin
      bad++; $display("FAIL inv_in_en: intt=%0d ntt=%0d baddata=%0d required 128/0/0", in_intt, in_ntt, in_bad); end
    total++; if (write_errors(1'b1, PAIRS) != 0) begin
      bad++; $display("FAIL inv_writes: %0d bad of %0d required 0 of 128", write_errors(1'b1, PAIRS), wr_log.size()); end
    total++; if (wr_log.size() == 0 || wr_log[0].cyc >= rd_last) begin
      bad++; $display("FAIL inv_overlap: first write not before last read (%0d)", rd_last); end
    total++; if (done_cnt != 1 || done_cyc - acc_cyc != PAIRS + 3 + 2) begin
      bad++; $display("FAIL inv_done: count=%0d at +%0d required 1 at +133", done_cnt, done_cyc - acc_cyc); end
    $display("test_inverse_overlap done: %0d spurious ntt_out_en", spur_cnt);
  endtask

  task automatic test_timeout();
    bit inv = 1'($urandom_range(0, 1));
    fill_ram(1'b0); cfg_lat = 40; cfg_limit = 100; cfg_extra = 0; cfg_spur = 1'b0;
    reset_env(); start_job(inv); wait_end();
    total++; if (err_cnt != 1 || done_cnt != 0) begin bad++; $display("FAIL tmo_pulse: err=%0d done=%0d required 1/0", err_cnt, done_cnt); end
    total++; if (write_errors(inv, 100) != 0) begin
      bad++; $display("FAIL tmo_writes: %0d bad of %0d required 0 of 100", write_errors(inv, 100), wr_log.size()); end
    total++; if (wr_log.size() == 0 || err_cyc - wr_log[wr_log.size()-1].cyc != TMO) begin
      bad++; $display("FAIL tmo_delay: err %0d after last output required %0d", err_cyc - (wr_log.size() ? wr_log[wr_log.size()-1].cyc : 0), TMO); end
    total++; if (ready_after_err !== 1'b1) begin bad++; $display("FAIL tmo_ready: got %b required 1", ready_after_err); end
    $display("test_timeout done: mode=%0d err at cycle %0d", inv, err_cyc);
  endtask

  task automatic test_reset_midfeed();
    int n = 0;
    bit inv = 1'($urandom_range(0, 1));
    fill_ram(1'b0); cfg_lat = 20; cfg_limit = 1000; cfg_extra = 0; cfg_spur = 1'b0;
    reset_env(); start_job(inv);
    do begin smp(); n++; end while (!(rd_en && rd_addr == AW'(50)) && n < 100);
    total++; if (n >= 100) begin bad++; $display("FAIL rst_reach: rd_addr 50 never seen"); end
    rst = 1'b1; pipe_q.delete();
    drv(); rst = 1'b0;
    smp();
    total++; if (outs_now !== '0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL rst_mid_outs: got %h ready=%b required 0 ready=1", outs_now, req_ready); end
    inv = 1'($urandom_range(0, 1));
    fill_ram(1'b0); reset_env(); start_job(inv); wait_end();
    total++; if (done_cnt != 1 || write_errors(inv, PAIRS) != 0) begin
      bad++; $display("FAIL rst_next_job: done=%0d badwrites=%0d required 1/0", done_cnt, write_errors(inv, PAIRS)); end
    $display("test_reset_midfeed done: follow-up mode=%0d", inv);
  endtask

  task automatic test_back_to_back();
    int n = 0, d1;
    bit b = 1'($urandom_range(0, 1));
    fill_ram(1'b0); cfg_lat = $urandom_range(2, 30); cfg_limit = 1000; cfg_extra = 0; cfg_spur = 1'b0;
    reset_env();
    drv(); req_valid = 1'b1; req_inv = 1'b0;
    do begin smp(); n++; end while (acc_cnt == 0 && n < 50);
    drv(); req_inv = b;
    n = 0;
    do begin smp(); n++; end while (done_cnt == 0 && n < 400);
    total++; if (done_cnt != 1 || write_errors(1'b0, PAIRS) != 0 || in_ntt != PAIRS) begin
      bad++; $display("FAIL b2b_job1: done=%0d badwrites=%0d ntt_in=%0d required 1/0/128", done_cnt, write_errors(1'b0, PAIRS), in_ntt); end
    d1 = done_cyc;
    reset_env();
    n = 0;
    do begin smp(); n++; end while (acc_cnt == 0 && n < 20);
    total++; if (acc_cyc != d1 + 1) begin bad++; $display("FAIL b2b_gap: second accept at done+%0d required done+1", acc_cyc - d1); end
    total++; if (acc_inv !== b) begin bad++; $display("FAIL b2b_mode_sample: got %b required %b", acc_inv, b); end
    drv(); req_valid = 1'b0;
    wait_end();
    total++; if ((b ? in_intt : in_ntt) != PAIRS || (b ? in_ntt : in_intt) != 0 || write_errors(b, PAIRS) != 0) begin
      bad++; $display("FAIL b2b_job2: ntt=%0d intt=%0d badwrites=%0d required mode %0d clean", in_ntt, in_intt, write_errors(b, PAIRS), b); end
    $display("test_back_to_back done: lat=%0d second mode=%0d", cfg_lat, b);
  endtask

  task automatic test_surplus();
    bit inv = 1'($urandom_range(0, 1));
    fill_ram(1'b0); cfg_lat = $urandom_range(2, 30); cfg_limit = 1000; cfg_extra = 2; cfg_spur = 1'b0;
    reset_env(); start_job(inv); wait_end(); cfg_extra = 0;
    total++; if (emitted != PAIRS + 2) begin bad++; $display("FAIL sur_emitted: got %0d required 130", emitted); end
    total++; if (write_errors(inv, PAIRS) != 0) begin
      bad++; $display("FAIL sur_writes: %0d bad of %0d required 0 of 128", write_errors(inv, PAIRS), wr_log.size()); end
    total++; if (done_cnt != 1 || err_cnt != 0) begin bad++; $display("FAIL sur_done: done=%0d err=%0d required 1/0", done_cnt, err_cnt); end
    $display("test_surplus done: mode=%0d lat=%0d writes=%0d", inv, cfg_lat, wr_log.size());
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_inv = 1'b0;
    rd_data1 = '0; rd_data2 = '0; ntt_out_en = 1'b0; intt_out_en = 1'b0;
    ntt_out1 = '0; ntt_out2 = '0; intt_out1 = '0; intt_out2 = '0;
    fill_ram(1'b1); reset_env();
    test_reset();
    test_forward();
    test_inverse_overlap();
    test_timeout();
    test_reset_midfeed();
    test_back_to_back();
    test_surplus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
